// File: rtl/pe_pkg.sv
// Shared sizes, operand-count helpers and loader state encoding for PE wrappers.
package pe_pkg;

  localparam int DEF_TILE_SIZE    = 4;
  localparam int DEF_KERNEL_SIZE  = 3;
  localparam int DEF_CHANNELS     = 3;
  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_KERNEL_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_HOLD
  } state_t;

  function automatic int calc_ni(input int tile_size, input int channels);
    return tile_size * tile_size * channels;
  endfunction

  function automatic int calc_nk(input int kernel_size, input int channels);
    return kernel_size * kernel_size * channels;
  endfunction

endpackage

// File: rtl/bram_read_stream.sv
// Issues N consecutive BRAM reads from a base address and shifts returned data into a flat bus.
// Data returns LAT cycles after each issue; first element returned ends up in the MSBs.
module bram_read_stream #(
  parameter int N   = 48,
  parameter int AW  = 15,
  parameter int W   = 8,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          launch,
  input  logic [AW-1:0] base,
  output logic [AW-1:0] addr,
  output logic          en,
  input  logic [W-1:0]  dout,
  output logic [N*W-1:0] flat,
  output logic          pending
);

  localparam int CW = $clog2(N + 1);

  logic [CW-1:0]  cnt;
  logic [LAT-1:0] vpipe;

  // cnt holds the number of the issue currently on the bus; wrap of addr is intentional
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr <= '0;
      en   <= 1'b0;
      cnt  <= '0;
    end else if (launch) begin
      addr <= base;
      en   <= 1'b1;
      cnt  <= CW'(1);
    end else if (en) begin
      if (cnt == CW'(N)) begin
        en <= 1'b0;
      end else begin
        addr <= addr + AW'(1);
        cnt  <= cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= en;
      for (int i = 1; i < LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
      end
    end
  end

  // Shifting in at the LSB places element k at slot N-1-k after N captures
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flat <= '0;
    end else if (vpipe[LAT-1]) begin
      flat <= {flat[N*W-W-1:0], dout};
    end
  end

  assign pending = en | (|vpipe);

endmodule

// File: rtl/pe_operand_loader.sv
// Fetches an input tile and optionally a kernel from BRAM and presents them flattened to a PE.
// operands_valid rises max(NI,NKeff)+BRAM_LATENCY+1 cycles after start; held until operands_ready.
module pe_operand_loader
  import pe_pkg::*;
#(
  parameter int TILE_SIZE     = DEF_TILE_SIZE,
  parameter int KERNEL_SIZE   = DEF_KERNEL_SIZE,
  parameter int CHANNELS      = DEF_CHANNELS,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int KERNEL_WIDTH  = DEF_KERNEL_WIDTH,
  parameter int BRAM_LATENCY  = 1,
  parameter int IN_ADDR_WIDTH = 15,
  parameter int K_ADDR_WIDTH  = 8,
  localparam int NI = calc_ni(TILE_SIZE, CHANNELS),
  localparam int NK = calc_nk(KERNEL_SIZE, CHANNELS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     reload_kernel,
  input  logic [IN_ADDR_WIDTH-1:0] in_base,
  input  logic [K_ADDR_WIDTH-1:0]  k_base,
  output logic                     busy,
  output logic [IN_ADDR_WIDTH-1:0] in_addr,
  output logic                     in_en,
  input  logic [DATA_WIDTH-1:0]    in_dout,
  output logic [K_ADDR_WIDTH-1:0]  k_addr,
  output logic                     k_en,
  input  logic [KERNEL_WIDTH-1:0]  k_dout,
  output logic [NI*DATA_WIDTH-1:0] flatten_input,
  output logic [NK*KERNEL_WIDTH-1:0] flatten_kernel,
  output logic                     operands_valid,
  input  logic                     operands_ready
);

  state_t state, state_nxt;
  logic   launch;
  logic   in_pending, k_pending;

  assign launch = (state == S_IDLE) && start;

  bram_read_stream #(
    .N(NI), .AW(IN_ADDR_WIDTH), .W(DATA_WIDTH), .LAT(BRAM_LATENCY)
  ) u_in_stream (
    .clk     (clk),
    .reset_n (reset_n),
    .launch  (launch),
    .base    (in_base),
    .addr    (in_addr),
    .en      (in_en),
    .dout    (in_dout),
    .flat    (flatten_input),
    .pending (in_pending)
  );

  // Kernel stream only launches on a reload, so its bus is untouched otherwise
  bram_read_stream #(
    .N(NK), .AW(K_ADDR_WIDTH), .W(KERNEL_WIDTH), .LAT(BRAM_LATENCY)
  ) u_k_stream (
    .clk     (clk),
    .reset_n (reset_n),
    .launch  (launch && reload_kernel),
    .base    (k_base),
    .addr    (k_addr),
    .en      (k_en),
    .dout    (k_dout),
    .flat    (flatten_kernel),
    .pending (k_pending)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: if (!in_en && !k_en) state_nxt = S_DRAIN;
      S_DRAIN: if (!in_pending && !k_pending) state_nxt = S_HOLD;
      S_HOLD:  if (operands_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy           = (state != S_IDLE);
  assign operands_valid = (state == S_HOLD);

endmodule

// File: tb/tb_pe_operand_loader.sv
// Directed bench: BRAM_LATENCY 1 and 3 loaders side by side against behavioural BRAMs.
module tb_pe_operand_loader;

  typedef struct {
    logic [14:0] in_base;
    logic [7:0]  k_base;
    logic        reload;
    logic [7:0]  in_ms;
    logic [7:0]  in_ls;
    logic [7:0]  k_ms;
    logic [7:0]  k_ls;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic reload_kernel = 1'b0;
  logic [14:0] in_base = '0;
  logic [7:0]  k_base = '0;
  logic operands_ready = 1'b0;

  logic busy1, in_en1, k_en1, valid1;
  logic [14:0] in_addr1;
  logic [7:0]  k_addr1;
  logic [7:0]  in_dout1 = '0, k_dout1 = '0;
  logic [383:0] flatten_input1;
  logic [215:0] flatten_kernel1;

  logic busy3, in_en3, k_en3, valid3;
  logic [14:0] in_addr3;
  logic [7:0]  k_addr3;
  logic [7:0]  in_dout3 = '0, k_dout3 = '0;
  logic [383:0] flatten_input3;
  logic [215:0] flatten_kernel3;

  int tests = 0;
  int fails = 0;
  logic [215:0] k_model = '0;

  always #5 clk = ~clk;

  pe_operand_loader #(.BRAM_LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .reload_kernel(reload_kernel),
    .in_base(in_base), .k_base(k_base), .busy(busy1),
    .in_addr(in_addr1), .in_en(in_en1), .in_dout(in_dout1),
    .k_addr(k_addr1), .k_en(k_en1), .k_dout(k_dout1),
    .flatten_input(flatten_input1), .flatten_kernel(flatten_kernel1),
    .operands_valid(valid1), .operands_ready(operands_ready)
  );

  pe_operand_loader #(.BRAM_LATENCY(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .start(start), .reload_kernel(reload_kernel),
    .in_base(in_base), .k_base(k_base), .busy(busy3),
    .in_addr(in_addr3), .in_en(in_en3), .in_dout(in_dout3),
    .k_addr(k_addr3), .k_en(k_en3), .k_dout(k_dout3),
    .flatten_input(flatten_input3), .flatten_kernel(flatten_kernel3),
    .operands_valid(valid3), .operands_ready(operands_ready)
  );

  // BRAM contents: in[a] = a[7:0], k[a] = 0x80 + a
  always @(posedge clk) begin
    if (in_en1) in_dout1 <= in_addr1[7:0];
    if (k_en1)  k_dout1  <= 8'h80 + k_addr1;
  end

  logic [14:0] ia1, ia2;
  logic [7:0]  ka1, ka2;
  logic        iv1 = 1'b0, iv2 = 1'b0, kv1 = 1'b0, kv2 = 1'b0;
  always @(posedge clk) begin
    ia1 <= in_addr3; iv1 <= in_en3; ia2 <= ia1; iv2 <= iv1;
    ka1 <= k_addr3;  kv1 <= k_en3;  ka2 <= ka1; kv2 <= kv1;
    if (iv2) in_dout3 <= ia2[7:0];
    if (kv2) k_dout3  <= 8'h80 + ka2;
  end

  // Address-sequence monitor on the latency-1 instance
  logic        mon_clr = 1'b0;
  logic [14:0] mon_base = '0;
  logic [7:0]  mon_kbase = '0;
  logic [14:0] exp_ia = '0;
  logic [7:0]  exp_ka = '0;
  int addr_err = 0, in_issues = 0, k_issues = 0;
  always @(posedge clk) begin
    if (mon_clr) begin
      addr_err <= 0; in_issues <= 0; k_issues <= 0;
      exp_ia <= mon_base; exp_ka <= mon_kbase;
    end else begin
      if (in_en1) begin
        if (in_addr1 !== exp_ia) addr_err <= addr_err + 1;
        exp_ia <= exp_ia + 15'd1;
        in_issues <= in_issues + 1;
      end
      if (k_en1) begin
        if (k_addr1 !== exp_ka) addr_err <= addr_err + 1;
        exp_ka <= exp_ka + 8'd1;
        k_issues <= k_issues + 1;
      end
    end
  end

  function automatic logic [383:0] exp_in(input logic [14:0] base);
    logic [383:0] r;
    logic [14:0] a;
    r = '0;
    for (int k = 0; k < 48; k++) begin
      a = base + 15'(k);
      r[(47-k)*8 +: 8] = a[7:0];
    end
    return r;
  endfunction

  function automatic logic [215:0] exp_k(input logic [7:0] base);
    logic [215:0] r;
    logic [7:0] a;
    r = '0;
    for (int j = 0; j < 27; j++) begin
      a = base + 8'(j);
      r[(26-j)*8 +: 8] = 8'h80 + a;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic release_hold();
    operands_ready = 1'b1;
    @(posedge clk); #1;
    operands_ready = 1'b0;
    check("valid_drop_l1", valid1, 1'b0);
    check("valid_drop_l3", valid3, 1'b0);
    check("idle_after_ready", busy1, 1'b0);
  endtask

  task automatic run_load(input vec_t v, input bit release_after);
    int lat1, lat3;
    logic [383:0] ei;
    lat1 = -1;
    lat3 = -1;
    mon_base = v.in_base; mon_kbase = v.k_base; mon_clr = 1'b1;
    in_base = v.in_base; k_base = v.k_base; reload_kernel = v.reload; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mon_clr = 1'b0; reload_kernel = 1'b0;
    if (v.reload) k_model = exp_k(v.k_base);
    ei = exp_in(v.in_base);
    for (int c = 1; c <= 120; c++) begin
      @(posedge clk); #1;
      if (valid1 && lat1 < 0) lat1 = c;
      if (valid3 && lat3 < 0) lat3 = c;
      if (lat1 >= 0 && lat3 >= 0) break;
    end
    check("latency_l1", lat1, 50);
    check("latency_l3", lat3, 52);
    check("busy_in_hold", busy1, 1'b1);
    check("in_bus_l1", flatten_input1, ei);
    check("k_bus_l1", flatten_kernel1, k_model);
    check("in_bus_l3", flatten_input3, ei);
    check("k_bus_l3", flatten_kernel3, k_model);
    check("in_ms_byte", flatten_input1[383:376], v.in_ms);
    check("in_ls_byte", flatten_input1[7:0], v.in_ls);
    check("k_ms_byte", flatten_kernel1[215:208], v.k_ms);
    check("k_ls_byte", flatten_kernel1[7:0], v.k_ls);
    check("addr_sequence", addr_err, 0);
    check("in_issue_count", in_issues, 48);
    check("k_issue_count", k_issues, v.reload ? 27 : 0);
    if (release_after) release_hold();
  endtask

  vec_t vecs[5];

  initial begin
    int bad;
    vecs[0] = '{in_base: 15'h0040, k_base: 8'h00, reload: 1'b0, in_ms: 8'h40, in_ls: 8'h6F, k_ms: 8'h00, k_ls: 8'h00};
    vecs[1] = '{in_base: 15'h0000, k_base: 8'h00, reload: 1'b1, in_ms: 8'h00, in_ls: 8'h2F, k_ms: 8'h80, k_ls: 8'h9A};
    vecs[2] = '{in_base: 15'h0100, k_base: 8'h55, reload: 1'b0, in_ms: 8'h00, in_ls: 8'h2F, k_ms: 8'h80, k_ls: 8'h9A};
    vecs[3] = '{in_base: 15'h7FF0, k_base: 8'h10, reload: 1'b1, in_ms: 8'hF0, in_ls: 8'h1F, k_ms: 8'h90, k_ls: 8'hAA};
    vecs[4] = '{in_base: 15'h0020, k_base: 8'hF0, reload: 1'b1, in_ms: 8'h20, in_ls: 8'h4F, k_ms: 8'h70, k_ls: 8'h8A};

    #12;
    check("reset_ctrl", {valid1, busy1, in_en1, k_en1, valid3, busy3}, 6'b0);
    check("reset_in_bus", flatten_input1, '0);
    check("reset_k_bus", flatten_kernel1, '0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 5; i++) run_load(vecs[i], 1'b1);

    // Hold with ready low: buses frozen, start ignored
    run_load(vecs[1], 1'b0);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        in_base = 15'h1234; k_base = 8'h33; reload_kernel = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0; reload_kernel = 1'b0;
      end
      @(posedge clk); #1;
      if (flatten_input1 !== exp_in(15'h0000) || flatten_kernel1 !== k_model ||
          !valid1 || !valid3 || in_en1 || k_en1 || flatten_input3 !== exp_in(15'h0000))
        bad++;
    end
    start = 1'b0;
    check("hold_stable", bad, 0);
    release_hold();
    @(posedge clk); #1;
    check("start_ignored_in_hold", {busy1, busy3}, 2'b00);

    // Reset asserted in the middle of FETCH
    in_base = 15'h0000; k_base = 8'h00; reload_kernel = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; reload_kernel = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("midload_fetching", {busy1, in_en1, k_en1}, 3'b111);
    reset_n = 1'b0;
    #1;
    check("abort_ctrl", {valid1, busy1, in_en1, k_en1, valid3, busy3, in_en3, k_en3}, 8'b0);
    check("abort_addr", {in_addr1, k_addr1}, 23'b0);
    check("abort_in_bus", flatten_input1, '0);
    check("abort_k_bus", flatten_kernel1, '0);
    @(negedge clk);
    reset_n = 1'b1;
    k_model = '0;
    run_load(vecs[1], 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
